// File: rtl/cmos_pixel_packer.sv
// CMOS capture stage: pairs 8-bit sensor bytes into 16-bit FIFO words, skips settling frames,
// flags FIFO overflow and line/frame length errors. Optional line tag words: CMOS_LINE_TAG_EN.
module cmos_pixel_packer #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_WORDS     = 640,
  parameter int V_LINES     = 480
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic        frame_done,
  output logic [11:0] line_cnt,
  output logic        overflow,
  output logic        len_err
);

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t      state_q;
  logic        vs_d0_q;
  logic        vs_d1_q;
  logic        href_d0_q;
  logic        href_d1_q;
  logic [7:0]  data_d0_q;
  logic [15:0] skip_cnt_q;
  logic        phase_q;
  logic [7:0]  hi_q;
  logic [15:0] word_cnt_q;

  logic        vs_rise_s;
  logic        href_fall_s;
  logic [15:0] line_words_s;

  assign vs_rise_s    = vs_d0_q & ~vs_d1_q;
  assign href_fall_s  = ~href_d0_q & href_d1_q;
  // A pending high byte at line end becomes a padded word, so it counts toward the line length.
  assign line_words_s = word_cnt_q + {15'd0, phase_q};

`ifdef CMOS_LINE_TAG_EN
  logic href_rise_s;
  assign href_rise_s = href_d0_q & ~href_d1_q;
`endif

  // Input registers and edge-detect history.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d0_q   <= 1'b0;
      vs_d1_q   <= 1'b0;
      href_d0_q <= 1'b0;
      href_d1_q <= 1'b0;
      data_d0_q <= 8'h00;
    end else begin
      vs_d0_q   <= cmos_vsync;
      vs_d1_q   <= vs_d0_q;
      href_d0_q <= cmos_href;
      href_d1_q <= href_d0_q;
      data_d0_q <= cmos_data;
    end
  end

  // Frame FSM, byte pairing, FIFO write and status flags.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SKIP;
      skip_cnt_q   <= 16'd0;
      phase_q      <= 1'b0;
      hi_q         <= 8'h00;
      word_cnt_q   <= 16'd0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 16'h0000;
      frame_done   <= 1'b0;
      line_cnt     <= 12'd0;
      overflow     <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        ST_SKIP: begin
          if (vs_rise_s) begin
            if (skip_cnt_q == 16'(SKIP_FRAMES - 1)) begin
              state_q    <= ST_WAIT_VS;
              skip_cnt_q <= 16'd0;
            end else begin
              skip_cnt_q <= skip_cnt_q + 16'd1;
            end
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise_s) begin
            state_q    <= ST_ACTIVE;
            line_cnt   <= 12'd0;
            overflow   <= 1'b0;
            len_err    <= 1'b0;
            phase_q    <= 1'b0;
            word_cnt_q <= 16'd0;
          end
        end
        ST_ACTIVE: begin
          if (vs_rise_s) begin
            // Frame boundary wins over a simultaneous line end: partial byte is discarded.
            frame_done <= 1'b1;
            len_err    <= (line_cnt != 12'(V_LINES));
            overflow   <= 1'b0;
            line_cnt   <= 12'd0;
            phase_q    <= 1'b0;
            word_cnt_q <= 16'd0;
          end else if (href_d0_q) begin
`ifdef CMOS_LINE_TAG_EN
            if (href_rise_s) begin
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {4'hA, line_cnt};
              end
            end
`endif
            if (!phase_q) begin
              hi_q    <= data_d0_q;
              phase_q <= 1'b1;
            end else begin
              phase_q    <= 1'b0;
              word_cnt_q <= word_cnt_q + 16'd1;
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {hi_q, data_d0_q};
              end
            end
          end else if (href_fall_s) begin
            if (phase_q) begin
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= {hi_q, 8'h00};
              end
            end
            if (line_words_s != 16'(H_WORDS)) begin
              len_err <= 1'b1;
            end
            if (line_cnt != 12'hFFF) begin
              line_cnt <= line_cnt + 12'd1;
            end
            word_cnt_q <= 16'd0;
            phase_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_SKIP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer with small frame geometry (SKIP 2, 8 words x 4 lines).
module tb_cmos_pixel_packer;

  localparam int SKIP = 2;
  localparam int HW   = 8;
  localparam int VL   = 4;

  logic        clk;
  logic        rst_n;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        frame_done;
  logic [11:0] line_cnt;
  logic        overflow;
  logic        len_err;

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_cnt   = 0;
  int   cyc      = 0;

  cmos_pixel_packer #(.SKIP_FRAMES(SKIP), .H_WORDS(HW), .V_LINES(VL)) dut (
    .cmos_pclk   (clk),
    .rst_n       (rst_n),
    .cmos_vsync  (cmos_vsync),
    .cmos_href   (cmos_href),
    .cmos_data   (cmos_data),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .frame_done  (frame_done),
    .line_cnt    (line_cnt),
    .overflow    (overflow),
    .len_err     (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every FIFO write is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (fifo_wr_en) begin
      exp_t e;
      n_checks = n_checks + 1;
      if (q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_write: got %04h, expected no write", fifo_wr_data);
      end else begin
        e = q.pop_front();
        if (fifo_wr_data !== e.d || (e.cyc >= 0 && e.cyc != cyc)) begin
          n_fail = n_fail + 1;
          $display("FAIL write_word: got %04h at cycle %0d, expected %04h at cycle %0d",
                   fifo_wr_data, cyc, e.d, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input int c);
    exp_t e;
    e.d   = d;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    cmos_vsync = 1'b1;
    idle(3);
    cmos_vsync = 1'b0;
    idle(3);
  endtask

  // Sends one line; when active, pushes the words it expects (full_win drops words 1..3).
  task automatic send_line(input int nbytes, input logic [7:0] base, input bit active,
                           input int ln, input bit full_win, input bit lat);
    logic [7:0] prev;
    logic [7:0] b;
    prev = 8'h00;
`ifdef CMOS_LINE_TAG_EN
    if (active) push({4'hA, 12'(ln)}, -1);
`endif
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      b = base + 8'(i);
      cmos_href = 1'b1;
      cmos_data = b;
      fifo_full = full_win && i >= 4 && i <= 9;
      if (active && (i % 2) == 1 && !(full_win && i >= 3 && i <= 7))
        push({prev, b}, lat ? cyc + 2 : -1);
      prev = b;
    end
    if (active && (nbytes % 2) == 1) push({prev, 8'h00}, -1);
    @(negedge clk);
    cmos_href = 1'b0;
    fifo_full = 1'b0;
    idle(4);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    cmos_data  = 8'h00;
    fifo_full  = 1'b0;
    idle(3);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_line_cnt", 32'(line_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    send_line(4, 8'hAA, 1'b0, 0, 1'b0, 1'b0);
    vs_pulse();
    send_line(4, 8'hBB, 1'b0, 0, 1'b0, 1'b0);
    vs_pulse();
    send_line(4, 8'hCC, 1'b0, 0, 1'b0, 1'b0);
    vs_pulse();
    chk("no_frame_done_on_entry", 32'(fd_cnt), 32'd0);

    send_line(2, 8'h01, 1'b1, 0, 1'b0, 1'b1);
    chk("line1_cnt", 32'(line_cnt), 32'd1);
    chk("line1_len_err", 32'(len_err), 32'd1);
    send_line(5, 8'h11, 1'b1, 1, 1'b0, 1'b0);
    chk("odd_line_cnt", 32'(line_cnt), 32'd2);
    chk("odd_len_err", 32'(len_err), 32'd1);

    // Abort: vsync rises on the same cycle href falls with a dangling high byte.
`ifdef CMOS_LINE_TAG_EN
    push({4'hA, 12'd2}, -1);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_data = 8'h21 + 8'(i);
    end
    push(16'h2122, -1);
    @(negedge clk);
    cmos_href  = 1'b0;
    cmos_vsync = 1'b1;
    idle(3);
    cmos_vsync = 1'b0;
    idle(3);
    chk("abort_line_cnt", 32'(line_cnt), 32'd0);
    chk("abort_frame_done", 32'(fd_cnt), 32'd1);
    chk("abort_queue_drained", 32'(q.size()), 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_len_err", 32'(len_err), 32'd0);
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    rst_n = 1'b1;
    idle(2);

    vs_pulse();
    send_line(4, 8'hDD, 1'b0, 0, 1'b0, 1'b0);
    vs_pulse();
    send_line(4, 8'hEE, 1'b0, 0, 1'b0, 1'b0);
    vs_pulse();

    for (int ln = 0; ln < VL; ln++) begin
      send_line(2 * HW, 8'h40 + 8'(ln * 16), 1'b1, ln, ln == 0, 1'b0);
      if (ln == 0) begin
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_len_err", 32'(len_err), 32'd0);
      end
    end
    chk("frame_line_cnt", 32'(line_cnt), 32'(VL));
    chk("frame_len_err", 32'(len_err), 32'd0);
    vs_pulse();
    chk("frame_done_cnt", 32'(fd_cnt), 32'd2);
    chk("post_frame_line_cnt", 32'(line_cnt), 32'd0);
    chk("post_frame_overflow", 32'(overflow), 32'd0);
    chk("post_frame_len_err", 32'(len_err), 32'd0);
    chk("final_queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
